// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags
// and a selectable read mode (registered read or first-word-fall-through).
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iPush,
  input  logic [DATA_W-1:0] iWrData,
  input  logic              iPop,
  output logic [DATA_W-1:0] oRdData,
  output logic              oRdValid,
  output logic              oFull,
  output logic              oEmpty,
  output logic              oAlmostFull,
  output logic              oAlmostEmpty,
  output logic [ADDR_W:0]   oCount,
  input  logic              iClrErr,
  output logic              oOverflow,
  output logic              oUnderflow
);

  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] L_AF    = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] L_AE    = (ADDR_W + 1)'(AE_THRESH);

  // Storage is deliberately left out of reset.
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic [ADDR_W:0] r_count;
  logic            r_full;
  logic            r_empty;
  logic            r_afull;
  logic            r_aempty;
  logic            r_ovf;
  logic            r_unf;

  logic            w_push_ok;
  logic            w_pop_ok;
  logic [ADDR_W:0] w_wr_ptr_nxt;
  logic [ADDR_W:0] w_rd_ptr_nxt;
  logic [ADDR_W:0] w_count_nxt;
  logic [DATA_W-1:0] w_head;

  // Accept decisions use the flags as they stand this cycle, so a full FIFO
  // still drains on push+pop and an empty FIFO still fills on push+pop.
  always_comb begin
    w_push_ok    = iPush & ~r_full;
    w_pop_ok     = iPop & ~r_empty;
    w_wr_ptr_nxt = r_wr_ptr + {{ADDR_W{1'b0}}, w_push_ok};
    w_rd_ptr_nxt = r_rd_ptr + {{ADDR_W{1'b0}}, w_pop_ok};
    w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
    w_head       = r_mem[r_rd_ptr[ADDR_W-1:0]];
  end

  // Write accepted words into the slot addressed by the write pointer.
  always_ff @(posedge iClk) begin
    if (w_push_ok && !iRst) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= iWrData;
    end
  end

  // Advance pointers and register occupancy flags from the post-edge count.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == L_DEPTH);
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= L_AF);
      r_aempty <= (w_count_nxt <= L_AE);
    end
  end

  // Sticky error flags; a new error event outranks a clear in the same cycle.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (iPush && r_full) begin
        r_ovf <= 1'b1;
      end else if (iClrErr) begin
        r_ovf <= 1'b0;
      end
      if (iPop && r_empty) begin
        r_unf <= 1'b1;
      end else if (iClrErr) begin
        r_unf <= 1'b0;
      end
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATA_W-1:0] r_rd_data;
      logic              r_rd_valid;

      // Capture the head word on each accepted pop; valid is a one-cycle pulse.
      always_ff @(posedge iClk) begin
        if (iRst) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_pop_ok;
          if (w_pop_ok) begin
            r_rd_data <= w_head;
          end
        end
      end

      assign oRdData  = r_rd_data;
      assign oRdValid = r_rd_valid;
    end else begin : g_fwft_read
      // Head word is always on display while the FIFO holds data.
      assign oRdData  = r_empty ? '0 : w_head;
      assign oRdValid = ~r_empty;
    end
  endgenerate

  assign oFull        = r_full;
  assign oEmpty       = r_empty;
  assign oAlmostFull  = r_afull;
  assign oAlmostEmpty = r_aempty;
  assign oCount       = r_count;
  assign oOverflow    = r_ovf;
  assign oUnderflow   = r_unf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one instance in registered-read mode,
// one in first-word-fall-through mode, both 8 bits x 16 entries.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  int         total = 0;
  int         bad = 0;

  // Registered-read instance
  logic       rst0, push0, pop0, clr0;
  logic [7:0] wd0, rd0;
  logic       vld0, full0, empty0, af0, ae0, ovf0, unf0;
  logic [4:0] cnt0;

  // FWFT instance
  logic       rst1, push1, pop1, clr1;
  logic [7:0] wd1, rd1;
  logic       vld1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] cnt1;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u0 (
    .iClk(clk), .iRst(rst0), .iPush(push0), .iWrData(wd0), .iPop(pop0),
    .oRdData(rd0), .oRdValid(vld0), .oFull(full0), .oEmpty(empty0),
    .oAlmostFull(af0), .oAlmostEmpty(ae0), .oCount(cnt0), .iClrErr(clr0),
    .oOverflow(ovf0), .oUnderflow(unf0)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u1 (
    .iClk(clk), .iRst(rst1), .iPush(push1), .iWrData(wd1), .iPop(pop1),
    .oRdData(rd1), .oRdValid(vld1), .oFull(full1), .oEmpty(empty1),
    .oAlmostFull(af1), .oAlmostEmpty(ae1), .oCount(cnt1), .iClrErr(clr1),
    .oOverflow(ovf1), .oUnderflow(unf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set before the call are sampled at that edge,
  // outputs are then checked 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    push0 = 1'b0; pop0 = 1'b0; clr0 = 1'b0; rst0 = 1'b0;
  endtask

  initial begin
    rst0 = 1'b1; push0 = 1'b0; pop0 = 1'b0; clr0 = 1'b0; wd0 = 8'h00;
    rst1 = 1'b1; push1 = 1'b0; pop1 = 1'b0; clr1 = 1'b0; wd1 = 8'h00;
    step();
    rst0 = 1'b0; rst1 = 1'b0;

    // Reset state
    chk("rst_cnt", cnt0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);
    chk("rst_ae", ae0, 1);
    chk("rst_af", af0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_unf", unf0, 0);
    chk("rst_vld", vld0, 0);
    chk("rst_rd", rd0, 0);

    // Fill with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      push0 = 1'b1; wd0 = 8'(i);
      step();
      chk("fill_cnt", cnt0, i + 1);
      chk("fill_empty", empty0, 0);
      chk("fill_full", full0, (i + 1 == 16) ? 1 : 0);
      chk("fill_af", af0, (i + 1 >= 14) ? 1 : 0);
      chk("fill_ae", ae0, (i + 1 <= 2) ? 1 : 0);
    end

    // Push while full
    wd0 = 8'hAA;
    step();
    chk("ovf_set", ovf0, 1);
    chk("ovf_cnt", cnt0, 16);
    idle0();
    step();
    chk("ovf_hold", ovf0, 1);
    clr0 = 1'b1;
    step();
    clr0 = 1'b0;
    chk("ovf_clr", ovf0, 0);

    // Drain: data appears one cycle after each pop
    for (int i = 0; i < 16; i++) begin
      pop0 = 1'b1;
      step();
      chk("pop_data", rd0, i);
      chk("pop_vld", vld0, 1);
      chk("pop_cnt", cnt0, 15 - i);
    end
    chk("drain_empty", empty0, 1);
    chk("drain_ovf", ovf0, 0);

    // Pop while empty
    step();
    pop0 = 1'b0;
    chk("unf_set", unf0, 1);
    chk("unf_vld", vld0, 0);
    chk("unf_hold_data", rd0, 8'h0F);
    clr0 = 1'b1;
    step();
    clr0 = 1'b0;
    chk("unf_clr", unf0, 0);

    // Preload 5 words, then 20 cycles of simultaneous push+pop
    for (int i = 0; i < 5; i++) begin
      push0 = 1'b1; wd0 = 8'(8'h10 + i);
      step();
    end
    chk("pre5_cnt", cnt0, 5);
    for (int k = 0; k < 20; k++) begin
      push0 = 1'b1; pop0 = 1'b1; wd0 = 8'(8'h15 + k);
      step();
      chk("pp_cnt", cnt0, 5);
      chk("pp_data", rd0, 8'h10 + k);
      chk("pp_vld", vld0, 1);
    end
    idle0();
    step();
    chk("pp_vld_end", vld0, 0);
    chk("pp_ovf", ovf0, 0);
    chk("pp_unf", unf0, 0);

    // Reset mid-operation with push and pop requested
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push0 = 1'b1; wd0 = 8'(8'h30 + i);
      step();
    end
    chk("pre_rst_cnt", cnt0, 8);
    rst0 = 1'b1; push0 = 1'b1; pop0 = 1'b1; wd0 = 8'h77;
    step();
    idle0();
    chk("mrst_cnt", cnt0, 0);
    chk("mrst_empty", empty0, 1);
    chk("mrst_vld", vld0, 0);
    chk("mrst_ovf", ovf0, 0);
    chk("mrst_unf", unf0, 0);
    chk("mrst_rd", rd0, 0);
    push0 = 1'b1; wd0 = 8'h42;
    step();
    push0 = 1'b0; pop0 = 1'b1;
    step();
    pop0 = 1'b0;
    chk("mrst_first", rd0, 8'h42);
    chk("mrst_empty2", empty0, 1);

    // Push+pop on empty: push wins, underflow set
    push0 = 1'b1; pop0 = 1'b1; wd0 = 8'h50;
    step();
    chk("ep_cnt", cnt0, 1);
    chk("ep_unf", unf0, 1);
    chk("ep_vld", vld0, 0);
    pop0 = 1'b0;
    for (int i = 1; i < 16; i++) begin
      wd0 = 8'(8'h50 + i);
      step();
    end
    chk("ep_full", full0, 1);

    // Push+pop on full with clear: pop wins, overflow set beats clear,
    // underflow (no new event) clears
    push0 = 1'b1; pop0 = 1'b1; clr0 = 1'b1; wd0 = 8'h60;
    step();
    idle0();
    chk("fp_cnt", cnt0, 15);
    chk("fp_ovf", ovf0, 1);
    chk("fp_unf", unf0, 0);
    chk("fp_data", rd0, 8'h50);
    chk("fp_full", full0, 0);

    // FWFT instance
    chk("fw_rst_vld", vld1, 0);
    chk("fw_rst_rd", rd1, 0);
    push1 = 1'b1; wd1 = 8'h5A;
    step();
    push1 = 1'b0;
    chk("fw_show_rd", rd1, 8'h5A);
    chk("fw_show_vld", vld1, 1);
    chk("fw_show_cnt", cnt1, 1);
    push1 = 1'b1; wd1 = 8'h6B;
    step();
    push1 = 1'b0;
    chk("fw_head_kept", rd1, 8'h5A);
    pop1 = 1'b1;
    step();
    chk("fw_next", rd1, 8'h6B);
    chk("fw_next_vld", vld1, 1);
    step();
    pop1 = 1'b0;
    chk("fw_empty", empty1, 1);
    chk("fw_empty_rd", rd1, 0);
    chk("fw_empty_vld", vld1, 0);
    chk("fw_unf", unf1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on total run time
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
